// File: rtl/etapa_busqueda.sv
// etapa_busqueda: instruction-fetch stage in front of a combinational ROM.
// Drives the ROM byte address from the PC and registers the returned word
// into the IF/ID pipeline register. It handles redirects, stalls and
// flushes, and keeps a count of fetched instructions.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold PC and IF/ID contents
//   salto_en          redirect request from EX (wins over stall)
//   dir_salto         redirect target byte address
//   instruccion       ROM data word, combinational in direccion
//   direccion         current PC (ROM address), always word aligned
//   instr_id          IF/ID instruction (all-zero NOP when flushed)
//   pc4_id            IF/ID PC+4
//   valido_id         IF/ID holds a real fetched instruction
//   err_alineacion    sticky: a misaligned redirect target was seen
//   cuenta_instr      instructions accepted into IF/ID (wraps)
//
// Optional feature: define FETCH_SALTO_TEMPRANO_EN to resolve J-type
// jumps (opcode 2) at fetch time with no bubble.
module etapa_busqueda #(
    parameter logic [31:0] PC_INICIAL   = 32'h0000_0000,
    parameter int          ANCHO_CUENTA = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    salto_en,
    input  logic [31:0]             dir_salto,
    input  logic [31:0]             instruccion,
    output logic [31:0]             direccion,
    output logic [31:0]             instr_id,
    output logic [31:0]             pc4_id,
    output logic                    valido_id,
    output logic                    err_alineacion,
    output logic [ANCHO_CUENTA-1:0] cuenta_instr
);

    logic [31:0] direccion_plus4;
    logic [31:0] pc_siguiente;

    assign direccion_plus4 = direccion + 32'd4;

    // Next PC on a plain fetch cycle (no redirect, no stall).
    always_comb begin
        pc_siguiente = direccion_plus4;
`ifdef FETCH_SALTO_TEMPRANO_EN
        if (instruccion[31:26] == 6'd2) begin
            pc_siguiente = {direccion_plus4[31:28],
                            instruccion[25:0], 2'b00};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            direccion      <= {PC_INICIAL[31:2], 2'b00};
            instr_id       <= 32'h0;
            pc4_id         <= 32'h0;
            valido_id      <= 1'b0;
            err_alineacion <= 1'b0;
            cuenta_instr   <= '0;
        end else if (salto_en) begin
            // Redirect flushes the wrong-path word as an all-zero NOP.
            direccion <= {dir_salto[31:2], 2'b00};
            instr_id  <= 32'h0;
            pc4_id    <= 32'h0;
            valido_id <= 1'b0;
            if (dir_salto[1:0] != 2'b00) begin
                err_alineacion <= 1'b1;
            end
        end else if (!stall) begin
            direccion    <= pc_siguiente;
            instr_id     <= instruccion;
            pc4_id       <= direccion_plus4;
            valido_id    <= 1'b1;
            cuenta_instr <= cuenta_instr + ANCHO_CUENTA'(1);
        end
    end

endmodule

// File: tb/tb_etapa_busqueda.sv
// tb_etapa_busqueda: directed test-plan sequence plus randomized traffic,
// compared every cycle against a spec-level model of the fetch stage.
module tb_etapa_busqueda;

    localparam int          CW  = 4;
    localparam logic [31:0] PC0 = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset, stall, salto_en;
    logic [31:0]   dir_salto;
    logic [31:0]   instruccion;
    logic [31:0]   direccion, instr_id, pc4_id;
    logic          valido_id, err_alineacion;
    logic [CW-1:0] cuenta_instr;

    logic [31:0] rom [64];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_on = 0;
    logic [31:0] m_pc, m_ins, m_pc4, w;
    bit          m_v, m_err;
    int          m_cnt;

    always #5 clk = ~clk;

    assign instruccion = rom[direccion[7:2]];

    etapa_busqueda #(.PC_INICIAL(PC0), .ANCHO_CUENTA(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .salto_en(salto_en),
        .dir_salto(dir_salto), .instruccion(instruccion),
        .direccion(direccion), .instr_id(instr_id), .pc4_id(pc4_id),
        .valido_id(valido_id), .err_alineacion(err_alineacion),
        .cuenta_instr(cuenta_instr)
    );

    always @(posedge clk) begin
        if (reset) begin
            m_on = 1; m_pc = PC0; m_ins = 0; m_pc4 = 0;
            m_v = 0; m_err = 0; m_cnt = 0;
        end else if (m_on && salto_en) begin
            m_pc = dir_salto & ~32'd3;
            m_ins = 0; m_pc4 = 0; m_v = 0;
            if (dir_salto % 4 != 0) m_err = 1;
        end else if (m_on && !stall) begin
            w = rom[(m_pc / 4) % 64];
            m_ins = w;
            m_pc4 = m_pc + 4;
            m_v = 1;
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_pc = m_pc + 4;
`ifdef FETCH_SALTO_TEMPRANO_EN
            if (w[31:26] == 6'd2)
                m_pc = {m_pc4[31:28], w[25:0], 2'b00};
`endif
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            checks++;
            if (direccion !== m_pc || instr_id !== m_ins ||
                pc4_id !== m_pc4 || valido_id !== m_v ||
                err_alineacion !== m_err ||
                cuenta_instr !== CW'(m_cnt)) begin
                errors++;
                $display("FAIL model t=%0t got dir=%h ins=%h pc4=%h v=%b e=%b c=%0d exp dir=%h ins=%h pc4=%h v=%b e=%b c=%0d",
                         $time, direccion, instr_id, pc4_id, valido_id,
                         err_alineacion, cuenta_instr, m_pc, m_ins, m_pc4,
                         m_v, m_err, m_cnt);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit sj,
                       input logic [31:0] ds);
        reset = r; stall = st; salto_en = sj; dir_salto = ds;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = $urandom;
            if (rom[i][31:26] == 6'd2) rom[i][31:26] = 6'd9;
        end
        rom[1] = {6'd8, 5'd0, 5'd16, 16'd1000};
        rom[9] = {6'd2, 26'd4};

        reset = 1; stall = 0; salto_en = 0; dir_salto = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0);
        lit("reset_dir", direccion, 32'h0);
        lit("reset_valid", {31'h0, valido_id}, 32'h0);

        cyc(0, 0, 0, 0);
        lit("seq_dir4", direccion, 32'd4);
        cyc(0, 0, 0, 0);
        lit("seq_instr", instr_id, {6'd8, 5'd0, 5'd16, 16'd1000});
        lit("seq_pc4", pc4_id, 32'd8);
        cyc(0, 0, 0, 0);
        lit("seq_dir12", direccion, 32'd12);
        lit("seq_cnt3", {28'h0, cuenta_instr}, 32'd3);
        cyc(0, 0, 0, 0);
        lit("seq_dir16", direccion, 32'd16);

        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        lit("stall_dir", direccion, 32'd16);
        lit("stall_pc4", pc4_id, 32'd16);
        lit("stall_cnt", {28'h0, cuenta_instr}, 32'd4);
        cyc(0, 0, 0, 0);
        lit("release_dir", direccion, 32'd20);

        cyc(0, 1, 1, 32'h8);
        lit("salto_dir", direccion, 32'd8);
        lit("salto_flush", instr_id, 32'h0);
        lit("salto_valid", {31'h0, valido_id}, 32'h0);
        lit("salto_err0", {31'h0, err_alineacion}, 32'h0);

        cyc(0, 0, 1, 32'h13);
        lit("mis_dir", direccion, 32'h10);
        lit("mis_err", {31'h0, err_alineacion}, 32'h1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        lit("mis_sticky", {31'h0, err_alineacion}, 32'h1);

        cyc(0, 0, 1, 32'd36);
        cyc(0, 0, 0, 0);
`ifdef FETCH_SALTO_TEMPRANO_EN
        lit("jmp_dir", direccion, 32'd16);
`else
        lit("jmp_dir", direccion, 32'd40);
`endif
        lit("jmp_instr", instr_id, {6'd2, 26'd4});
        lit("jmp_valid", {31'h0, valido_id}, 32'h1);

        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        lit("wrap_dir", direccion, 32'h0);
        lit("wrap_pc4", pc4_id, 32'h0);

        cyc(0, 0, 1, 32'h20);
        cyc(1, 0, 1, 32'h44);
        lit("rst_dir", direccion, PC0);
        lit("rst_instr", instr_id, 32'h0);
        lit("rst_err", {31'h0, err_alineacion}, 32'h0);
        lit("rst_cnt", {28'h0, cuenta_instr}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ds;
            int k;
            k = $urandom_range(0, 99);
            ds = $urandom_range(0, 255);
            if ($urandom_range(0, 19) == 0) ds = ds | 32'hFFFF_FF00;
            if ($urandom_range(0, 3) != 0) ds[1:0] = 2'b00;
            cyc(k < 1, $urandom_range(0, 99) < 30, k >= 1 && k < 11, ds);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/etapa_busqueda.md
Name: etapa_busqueda

Overview:
Instruction-fetch stage that sits directly upstream of the instruction ROM. It drives the ROM's byte address from a program counter and captures the combinational instruction the ROM returns into an IF/ID pipeline register for the decoder. It handles sequential fetch, redirects from downstream branch/jump resolution, stalls and flushes, and keeps a fetch counter.

Parameters:
PC_INICIAL, 32'h0000_0000, byte address loaded into PC on reset; must be word-aligned.
ANCHO_CUENTA, 16, width of the fetched-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
stall  input  1  hold PC and IF/ID contents (hazard unit)
salto_en  input  1  redirect request from branch/jump resolution (EX stage)
dir_salto  input  32  redirect target byte address
instruccion  input  32  instruction word from ROM; combinational function of direccion
direccion  output  32  current PC, drives ROM address
instr_id  output  32  IF/ID instruction register
pc4_id  output  32  IF/ID PC+4 register
valido_id  output  1  IF/ID contents are a real fetched instruction
err_alineacion  output  1  sticky flag: a misaligned redirect target was received
cuenta_instr  output  ANCHO_CUENTA  count of instructions accepted into IF/ID

Behaviour:
- Reset (synchronous, evaluated at rising edge, highest priority):
  - direccion=PC_INICIAL
  - instr_id=32'h0 (NOP), pc4_id=0, valido_id=0
  - err_alineacion=0, cuenta_instr=0
- Reset asserted mid-operation discards any pending redirect or stall in that same cycle.
- ROM is combinational: instruccion is sampled in the same cycle direccion is presented. Fetch latency is 1 cycle from PC to instr_id.
- Per-cycle priority, highest to lowest: reset > salto_en > stall > sequential.
- salto_en=1 (applies even when stall=1):
  - direccion <= {dir_salto[31:2],2'b00}
  - instr_id <= 32'h0, valido_id <= 0 (flush of wrong-path instruction), pc4_id <= 0
  - cuenta_instr unchanged
  - if dir_salto[1:0]!=0, err_alineacion <= 1; it stays 1 until reset
- stall=1, salto_en=0: direccion, instr_id, pc4_id, valido_id and cuenta_instr all hold.
- Sequential (no stall, no redirect):
  - direccion <= direccion+4
  - instr_id <= instruccion, pc4_id <= direccion+4, valido_id <= 1
  - cuenta_instr <= cuenta_instr+1
- Arithmetic:
  - PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
  - cuenta_instr wraps modulo 2^ANCHO_CUENTA.
- direccion[1:0] is always 2'b00.
- Hold the flush NOP as all-zero so the decoder treats it as sll $0,$0,0.
- No internal state machine beyond the PC/IF-ID registers. The effective modes are RESET, FETCH, STALL and REDIRECT, selected each cycle by the priority list above.

Optional Feature:
Macro FETCH_SALTO_TEMPRANO_EN.
- Defined: the stage decodes J-type jumps at fetch. When not stalled and with no salto_en, if instruccion[31:26]==6'd2:
  - direccion <= {direccion_plus4[31:28], instruccion[25:0], 2'b00} instead of direccion+4
  - the j instruction itself still enters IF/ID normally (valido_id=1, counted)
  - no bubble is inserted
  - salto_en in the same cycle overrides the early jump.
- Undefined: opcode 2 is treated as an ordinary instruction. The jump takes effect only through salto_en from downstream.

Test Plan:
- Reset, then 3 free-running cycles with ROM program loaded -> direccion 0, 4, 8, 12; instr_id after cycle 2 = {6'd8,5'd0,5'd16,16'd1000}; pc4_id=8; cuenta_instr=3.
- Assert stall for 2 cycles at direccion=16 -> direccion stays 16, instr_id/pc4_id/cuenta_instr frozen; release -> direccion 20 next edge.
- salto_en=1, dir_salto=32'h0000_0008 together with stall=1 -> next edge direccion=8, instr_id=0, valido_id=0, err_alineacion=0.
- salto_en=1, dir_salto=32'h0000_0013 -> direccion=32'h10, err_alineacion=1 and remains 1 for the following cycles until reset.
- With FETCH_SALTO_TEMPRANO_EN, fetch reaches direccion=36 (j 4) -> next edge direccion=16, instr_id={6'd2,26'd4}, valido_id=1. Without the macro -> direccion=40.
- Assert reset while direccion=0x20 and salto_en=1 -> next edge direccion=PC_INICIAL, all IF/ID outputs, err_alineacion and cuenta_instr zero.
